bcd_time_counter: RTL and testbench
===================================

// Module: bcd_time_counter
// PURPOSE
//  Parametrised hh:mm:ss BCD time counter; next generation of the seconds-only counter.
//  Three cascaded two-digit BCD stages with enable, built-in tick prescaler, up/down
//  counting and validated synchronous load. Drives 7-seg/display logic in lab designs.
//  Optional alarm compare on hh:mm.
// PARAMETERS
//  SEC_MOD   60  seconds modulus; counts 00..SEC_MOD-1 (2..60)
//  MIN_MOD   60  minutes modulus; counts 00..MIN_MOD-1 (2..60)
//  HOUR_MOD  24  hours modulus; counts 00..HOUR_MOD-1 (2..99; 12 or 24 typical)
//  TICK_DIV  1   enabled clk cycles per one-second step (>=1)
// PORTS
//  clk       in   1  rising-edge clock
//  rst       in   1  asynchronous reset, active-low (0 = reset)
//  en        in   1  count enable; 0 freezes prescaler and time
//  up        in   1  direction: 1 = count up, 0 = count down
//  load      in   1  synchronous load strobe
//  load_hh   in   8  BCD hours to load   ([7:4] tens, [3:0] units)
//  load_mm   in   8  BCD minutes to load
//  load_ss   in   8  BCD seconds to load
//  hh        out  8  BCD hours
//  mm        out  8  BCD minutes
//  ss        out  8  BCD seconds
//  day_wrap  out  1  1-cycle pulse on full-period wrap
//  load_err  out  1  1-cycle pulse: load rejected
// BEHAVIOUR
//  - Reset (rst=0, async): hh=mm=ss=8'h00, prescaler=0, day_wrap=0, load_err=0.
//  - Prescaler counts 0..TICK_DIV-1 while en=1; step fires on the cycle with en=1 and
//    prescaler==TICK_DIV-1; prescaler then returns to 0. TICK_DIV=1: step every en cycle.
//  - All outputs registered; a step updates hh/mm/ss at the same clk edge (latency 1).
//  - Up step: ss units+1; units 9 -> 0 with tens+1; ss==SEC_MOD-1 -> 00 and carry to mm;
//    same rule mm->hh; hh==HOUR_MOD-1 with carry -> 00.
//  - Down step: ss units-1; units 0 -> 9 with tens-1; ss==00 -> SEC_MOD-1 and borrow to mm;
//    same for mm->hh; hh==00 with borrow -> HOUR_MOD-1.
//  - day_wrap=1 for exactly the cycle after up-step MAX->00:00:00 or down-step 00:00:00->MAX.
//  - Units digit never leaves 0..9; outputs never exceed modulus-1.
//  - load has priority over step; on accepted load hh/mm/ss take load values,
//    prescaler cleared to 0, no step that cycle, day_wrap=0. Load ignores en.
//  - Load rejected (any digit >9 or value >= its modulus): time and prescaler unchanged,
//    no step that cycle, load_err=1 next cycle. Held load reloads every cycle.
//  - up may change any cycle; it takes effect on the next step.
//  - Reset mid-count: outputs clear immediately; counting resumes from 00:00:00 on the
//    first clk edge after rst returns to 1.
// CONFIGURATION
//  Macro TIME_ALARM_EN:
//  - Defined: extra ports alarm_set in 1, alarm_hh in 8, alarm_mm in 8, alarm out 1.
//    Valid alarm_set stores hh:mm and arms the alarm; invalid values are ignored and pulse
//    load_err. alarm=1 for one cycle after any step or load that makes time equal
//    alarm_hh:alarm_mm:00 while armed. Reset disarms the alarm and clears the register.
//  - Not defined: ports absent, no alarm logic; all other behaviour identical.
// STRUCTURE
//  - Package bcd_time_pkg: typedef bcd2_t (logic [7:0]); BCD_MAX_DIGIT=4'd9;
//    function bcd2_valid(value, mod); function bcd2_to_bin.
//  - Sub-module bcd2_mod_counter (MOD param): one two-digit stage with inc/dec, load,
//    carry/borrow out; instantiated three times with SEC_MOD, MIN_MOD, HOUR_MOD.
//  - Top: prescaler, load validation, cascade wiring, day_wrap, optional alarm.
// TESTING (defaults unless noted; TICK_DIV=1)
//  1. rst=0 mid-count at 12:34:56 -> hh/mm/ss=00:00:00 before next clk edge;
//     release rst, en=1, up=1 -> 00:00:01 after first edge.
//  2. load 23:59:58, up=1, 3 steps -> 23:59:59, 00:00:00 with day_wrap=1 on that cycle
//     only, 00:00:01.
//  3. load 00:00:01, up=0, 2 steps -> 00:00:00, then 23:59:59 with day_wrap=1;
//     next 23:59:58.
//  4. load_ss=8'h60, 8'h1A, load_hh=8'h24 (each alone) -> time unchanged, load_err=1
//     one cycle each; load 09:59:59 accepted, load_err=0.
//  5. TICK_DIV=4: en=1 for 8 cycles -> 2 steps; en=0 for 3 cycles -> time and prescaler
//     frozen; load+en same cycle -> loaded value, prescaler 0.
//  6. TIME_ALARM_EN, alarm_set 07:30, load 07:29:58, 2 steps -> alarm=1 one cycle at
//     07:30:00; HOUR_MOD=12: 11:59:59 +1 -> 00:00:00 with day_wrap.

Source files
------------

// File: rtl/bcd_time_pkg.sv
// Shared types and helpers for the two-digit BCD time stages.
// Used by bcd2_mod_counter and bcd_time_counter.
package bcd_time_pkg;

  typedef logic [7:0] bcd2_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  function automatic logic [7:0] bcd2_to_bin(input bcd2_t value);
    return 8'(value[7:4]) * 8'd10 + 8'(value[3:0]);
  endfunction

  // A value is usable only if both digits are decimal and it is below the modulus.
  function automatic logic bcd2_valid(input bcd2_t value, input int unsigned mod);
    return (value[7:4] <= BCD_MAX_DIGIT) && (value[3:0] <= BCD_MAX_DIGIT) &&
           (32'(bcd2_to_bin(value)) < mod);
  endfunction

  function automatic bcd2_t bin_to_bcd2(input int unsigned value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Next-state logic of one two-digit BCD modulo stage (00..MOD-1).
// The state register lives in the parent so the next value can feed the alarm compare.
module bcd2_mod_counter
  import bcd_time_pkg::*;
#(
  parameter int unsigned MOD = 60
) (
  input  bcd2_t value,
  input  logic  step,
  input  logic  up,
  input  logic  load,
  input  bcd2_t load_value,
  output bcd2_t next_value,
  output logic  carry
);

  localparam bcd2_t MAX_VALUE = bin_to_bcd2(MOD - 1);

  // carry doubles as borrow when counting down; it is only raised on a real step.
  always_comb begin
    next_value = value;
    carry      = 1'b0;
    if (load) begin
      next_value = load_value;
    end else if (step) begin
      if (up) begin
        if (value == MAX_VALUE) begin
          next_value = 8'h00;
          carry      = 1'b1;
        end else if (value[3:0] == BCD_MAX_DIGIT) begin
          next_value = {value[7:4] + 4'd1, 4'd0};
        end else begin
          next_value = {value[7:4], value[3:0] + 4'd1};
        end
      end else begin
        if (value == 8'h00) begin
          next_value = MAX_VALUE;
          carry      = 1'b1;
        end else if (value[3:0] == 4'd0) begin
          next_value = {value[7:4] - 4'd1, BCD_MAX_DIGIT};
        end else begin
          next_value = {value[7:4], value[3:0] - 4'd1};
        end
      end
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// hh:mm:ss BCD time counter with prescaler, up/down, validated load.
// Define TIME_ALARM_EN to add the hh:mm alarm ports and logic.
module bcd_time_counter
  import bcd_time_pkg::*;
#(
  parameter int unsigned SEC_MOD  = 60,
  parameter int unsigned MIN_MOD  = 60,
  parameter int unsigned HOUR_MOD = 24,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  up,
  input  logic  load,
  input  bcd2_t load_hh,
  input  bcd2_t load_mm,
  input  bcd2_t load_ss,
`ifdef TIME_ALARM_EN
  input  logic  alarm_set,
  input  bcd2_t alarm_hh,
  input  bcd2_t alarm_mm,
  output logic  alarm,
`endif
  output bcd2_t hh,
  output bcd2_t mm,
  output bcd2_t ss,
  output logic  day_wrap,
  output logic  load_err
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] prescaler;
  bcd2_t ss_next, mm_next, hh_next;
  logic  ss_carry, mm_carry, hh_carry;
  logic  load_ok, load_accept, tick, err_next;

  assign load_ok = bcd2_valid(load_hh, HOUR_MOD) && bcd2_valid(load_mm, MIN_MOD) &&
                   bcd2_valid(load_ss, SEC_MOD);
  assign load_accept = load && load_ok;
  // Any load, even a rejected one, suppresses the step of that cycle.
  assign tick = en && !load && (prescaler == PRE_LAST);

  bcd2_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .value(ss), .step(tick), .up(up), .load(load_accept), .load_value(load_ss),
    .next_value(ss_next), .carry(ss_carry)
  );

  bcd2_mod_counter #(.MOD(MIN_MOD)) u_min (
    .value(mm), .step(ss_carry), .up(up), .load(load_accept), .load_value(load_mm),
    .next_value(mm_next), .carry(mm_carry)
  );

  bcd2_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .value(hh), .step(mm_carry), .up(up), .load(load_accept), .load_value(load_hh),
    .next_value(hh_next), .carry(hh_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      hh        <= 8'h00;
      mm        <= 8'h00;
      ss        <= 8'h00;
      day_wrap  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (load) begin
        if (load_ok) prescaler <= '0;
      end else if (en) begin
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      end
      hh       <= hh_next;
      mm       <= mm_next;
      ss       <= ss_next;
      day_wrap <= hh_carry;
      load_err <= err_next;
    end
  end

`ifdef TIME_ALARM_EN
  bcd2_t alarm_hh_reg, alarm_mm_reg;
  logic  armed, alarm_ok;

  assign alarm_ok = bcd2_valid(alarm_hh, HOUR_MOD) && bcd2_valid(alarm_mm, MIN_MOD);
  assign err_next = (load && !load_ok) || (alarm_set && !alarm_ok);

  // Compare against the value being written so the pulse lines up with the new time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_hh_reg <= 8'h00;
      alarm_mm_reg <= 8'h00;
      armed        <= 1'b0;
      alarm        <= 1'b0;
    end else begin
      if (alarm_set && alarm_ok) begin
        alarm_hh_reg <= alarm_hh;
        alarm_mm_reg <= alarm_mm;
        armed        <= 1'b1;
      end
      alarm <= armed && (tick || load_accept) && (hh_next == alarm_hh_reg) &&
               (mm_next == alarm_mm_reg) && (ss_next == 8'h00);
    end
  end
`else
  assign err_next = load && !load_ok;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: two instances (24h/div1 and 12h/div4) against a
// seconds-of-day reference model; directed cases followed by random stimulus.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  logic rst;
  logic en[2], up[2], load[2];
  logic [7:0] load_hh[2], load_mm[2], load_ss[2];
  logic [7:0] hh[2], mm[2], ss[2];
  logic day_wrap[2], load_err[2];
`ifdef TIME_ALARM_EN
  logic alarm_set[2], alarm[2];
  logic [7:0] alarm_hh[2], alarm_mm[2];
`endif

  int checks = 0;
  int errors = 0;

  // model parameters and state, index 0 = dut_a, 1 = dut_b
  int sec_mod[2], min_mod[2], hour_mod[2], tick_div[2];
  int t[2], pre[2], alarm_t[2];
  bit e_wrap[2], e_err[2], e_alarm[2], armed[2];

  bcd_time_counter #(.SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(24), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en(en[0]), .up(up[0]), .load(load[0]),
    .load_hh(load_hh[0]), .load_mm(load_mm[0]), .load_ss(load_ss[0]),
`ifdef TIME_ALARM_EN
    .alarm_set(alarm_set[0]), .alarm_hh(alarm_hh[0]), .alarm_mm(alarm_mm[0]), .alarm(alarm[0]),
`endif
    .hh(hh[0]), .mm(mm[0]), .ss(ss[0]), .day_wrap(day_wrap[0]), .load_err(load_err[0])
  );

  bcd_time_counter #(.SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(12), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en(en[1]), .up(up[1]), .load(load[1]),
    .load_hh(load_hh[1]), .load_mm(load_mm[1]), .load_ss(load_ss[1]),
`ifdef TIME_ALARM_EN
    .alarm_set(alarm_set[1]), .alarm_hh(alarm_hh[1]), .alarm_mm(alarm_mm[1]), .alarm(alarm[1]),
`endif
    .hh(hh[1]), .mm(mm[1]), .ss(ss[1]), .day_wrap(day_wrap[1]), .load_err(load_err[1])
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int bcd_val(input logic [7:0] v, input int mod);
    int b;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    b = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (b >= mod) return -1;
    return b;
  endfunction

  function automatic logic [7:0] to_bcd(input int x);
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic int period(input int k);
    return sec_mod[k] * min_mod[k] * hour_mod[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; pre[k] = 0; alarm_t[k] = 0; armed[k] = 0;
      e_wrap[k] = 0; e_err[k] = 0; e_alarm[k] = 0;
    end
  endtask

  task automatic model_cycle(input int k);
    int h, m, s, p;
    bit moved;
    p = period(k);
    e_wrap[k] = 0; e_err[k] = 0; e_alarm[k] = 0; moved = 0;
    if (load[k]) begin
      h = bcd_val(load_hh[k], hour_mod[k]);
      m = bcd_val(load_mm[k], min_mod[k]);
      s = bcd_val(load_ss[k], sec_mod[k]);
      if (h >= 0 && m >= 0 && s >= 0) begin
        t[k] = (h * min_mod[k] + m) * sec_mod[k] + s;
        pre[k] = 0;
        moved = 1;
      end else begin
        e_err[k] = 1;
      end
    end else if (en[k]) begin
      if (pre[k] == tick_div[k] - 1) begin
        pre[k] = 0;
        moved = 1;
        if (up[k]) begin
          if (t[k] == p - 1) e_wrap[k] = 1;
          t[k] = (t[k] + 1) % p;
        end else begin
          if (t[k] == 0) e_wrap[k] = 1;
          t[k] = (t[k] + p - 1) % p;
        end
      end else begin
        pre[k] = pre[k] + 1;
      end
    end
`ifdef TIME_ALARM_EN
    if (moved && armed[k] && t[k] == alarm_t[k]) e_alarm[k] = 1;
    if (alarm_set[k]) begin
      h = bcd_val(alarm_hh[k], hour_mod[k]);
      m = bcd_val(alarm_mm[k], min_mod[k]);
      if (h >= 0 && m >= 0) begin
        armed[k] = 1;
        alarm_t[k] = (h * min_mod[k] + m) * sec_mod[k];
      end else begin
        e_err[k] = 1;
      end
    end
`else
    if (moved) e_alarm[k] = 0;
`endif
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input int k);
    string n;
    n = (k == 0) ? "a" : "b";
    check({n, "_hh"}, hh[k], to_bcd(t[k] / (min_mod[k] * sec_mod[k])));
    check({n, "_mm"}, mm[k], to_bcd((t[k] / sec_mod[k]) % min_mod[k]));
    check({n, "_ss"}, ss[k], to_bcd(t[k] % sec_mod[k]));
    check({n, "_day_wrap"}, day_wrap[k], e_wrap[k]);
    check({n, "_load_err"}, load_err[k], e_err[k]);
`ifdef TIME_ALARM_EN
    check({n, "_alarm"}, alarm[k], e_alarm[k]);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_cycle(0);
    model_cycle(1);
    @(posedge clk);
    #1;
    check_outputs(0);
    check_outputs(1);
  endtask

  task automatic set_idle(input int k);
    en[k] = 0; up[k] = 1; load[k] = 0;
    load_hh[k] = 8'h00; load_mm[k] = 8'h00; load_ss[k] = 8'h00;
`ifdef TIME_ALARM_EN
    alarm_set[k] = 0; alarm_hh[k] = 8'h00; alarm_mm[k] = 8'h00;
`endif
  endtask

  task automatic do_load(input int k, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    load[k] = 1; load_hh[k] = h; load_mm[k] = m; load_ss[k] = s;
    tick();
    load[k] = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] rand_bcd(input int mod);
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    if ($urandom_range(0, 2) == 0) return to_bcd(mod - 1 - int'($urandom_range(0, 1)));
    return to_bcd(int'($urandom_range(0, 99)) % (mod + 2));
  endfunction

  // ---------------- clock/reset and test sequence ----------------
  initial begin
    sec_mod[0] = 60; min_mod[0] = 60; hour_mod[0] = 24; tick_div[0] = 1;
    sec_mod[1] = 60; min_mod[1] = 60; hour_mod[1] = 12; tick_div[1] = 4;
    rst = 0;
    set_idle(0);
    set_idle(1);
    model_reset();
    #12;
    check_outputs(0);
    check_outputs(1);
    @(negedge clk);
    rst = 1;

    // reset in the middle of counting
    en[0] = 1;
    do_load(0, 8'h12, 8'h34, 8'h54);
    run(2);
    rst = 0;
    model_reset();
    #1;
    check_outputs(0);
    check_outputs(1);
    @(posedge clk);
    #1;
    check_outputs(0);
    @(negedge clk);
    rst = 1;
    tick();

    // up wrap across the full day
    en[0] = 1; up[0] = 1;
    do_load(0, 8'h23, 8'h59, 8'h58);
    run(3);

    // down wrap
    up[0] = 0;
    do_load(0, 8'h00, 8'h00, 8'h01);
    run(3);

    // rejected loads, then an accepted one
    en[0] = 0;
    do_load(0, 8'h10, 8'h20, 8'h60);
    tick();
    do_load(0, 8'h10, 8'h20, 8'h1A);
    do_load(0, 8'h24, 8'h20, 8'h30);
    do_load(0, 8'h09, 8'h59, 8'h59);
    tick();

    // prescaler on the divided instance
    en[1] = 1; up[1] = 1;
    run(8);
    en[1] = 0;
    run(3);
    en[1] = 1;
    run(2);
    do_load(1, 8'h05, 8'h06, 8'h07);
    run(5);

    // 12 hour wrap
    do_load(1, 8'h11, 8'h59, 8'h59);
    run(4);
    up[1] = 0;
    run(8);

`ifdef TIME_ALARM_EN
    en[0] = 0;
    alarm_set[0] = 1; alarm_hh[0] = 8'h07; alarm_mm[0] = 8'h30;
    tick();
    alarm_set[0] = 0;
    up[0] = 1; en[0] = 1;
    do_load(0, 8'h07, 8'h29, 8'h58);
    run(3);
    alarm_set[1] = 1; alarm_hh[1] = 8'h12; alarm_mm[1] = 8'h00;
    tick();
    alarm_set[1] = 0;
`endif

    // random phase
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        en[k] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) up[k] = ~up[k];
        load[k] = ($urandom_range(0, 40) == 0);
        load_hh[k] = rand_bcd(hour_mod[k]);
        load_mm[k] = rand_bcd(min_mod[k]);
        load_ss[k] = rand_bcd(sec_mod[k]);
`ifdef TIME_ALARM_EN
        alarm_set[k] = ($urandom_range(0, 200) == 0);
        alarm_hh[k] = rand_bcd(hour_mod[k]);
        alarm_mm[k] = rand_bcd(min_mod[k]);
`endif
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
